// File: rtl/simon_input_capture_pkg.sv
// ----------------------------------------------------------------
// simon_input_capture_pkg : colour codes, state encoding, timeout default
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package simon_input_capture_pkg;

  localparam logic [1:0] COLOR_GREEN  = 2'd0;
  localparam logic [1:0] COLOR_RED    = 2'd1;
  localparam logic [1:0] COLOR_YELLOW = 2'd2;
  localparam logic [1:0] COLOR_BLUE   = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd250_000_000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_t;

  // Only meaningful for a one-hot input; anything else maps to green.
  function automatic logic [1:0] encode_color(input logic [3:0] btn);
    logic [1:0] c;
    c = COLOR_GREEN;
    case (btn)
      4'b0010: c = COLOR_RED;
      4'b0100: c = COLOR_YELLOW;
      4'b1000: c = COLOR_BLUE;
      default: c = COLOR_GREEN;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon_input_capture_if.sv
// ----------------------------------------------------------------
// simon_input_capture_if : valid/ready colour-event handshake
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface simon_input_capture_if;
  logic       press_valid;
  logic       press_ready;
  logic [1:0] press_color;

  modport master (output press_valid, output press_color, input press_ready);
  modport slave  (input press_valid, input press_color, output press_ready);
endinterface

`default_nettype wire

// File: rtl/simon_btn_edge.sv
// ----------------------------------------------------------------
// simon_btn_edge : registers previous button levels, reports rises and one-hot
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module simon_btn_edge #(
  parameter int NUM_BTN = 4
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] clean_btn,
  output logic [NUM_BTN-1:0] rise,
  output logic               onehot
);

  logic [NUM_BTN-1:0] r_btn_prev;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_btn_prev <= '0;
    else        r_btn_prev <= clean_btn;
  end

  assign rise   = clean_btn & ~r_btn_prev;
  assign onehot = $onehot(clean_btn);

endmodule

`default_nettype wire

// File: rtl/simon_input_capture.sv
// ----------------------------------------------------------------
// simon_input_capture : debounced buttons -> validated player colour events
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module simon_input_capture
  import simon_input_capture_pkg::*;
#(
  parameter int          NUM_BTN        = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int          CNT_W          = 32
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic [NUM_BTN-1:0]    clean_btn,
  input  logic                  arm,
  simon_input_capture_if.master press,
  output logic                  timeout,
  output logic [NUM_BTN-1:0]    led_echo
);

  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_counter, w_counter_next;
  logic               r_valid, w_valid_next;
  logic [1:0]         r_color, w_color_next;
  logic [NUM_BTN-1:0] r_led, w_led_next;
  logic               r_timeout, w_timeout_next;

  logic [NUM_BTN-1:0] w_rise;
  logic               w_onehot;
  logic               w_accept;
  logic               w_chord;
  logic               w_timeout_hit;

  simon_btn_edge #(.NUM_BTN(NUM_BTN)) u_btn_edge (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .clean_btn (clean_btn),
    .rise      (w_rise),
    .onehot    (w_onehot)
  );

  assign w_accept      = (w_rise != '0) && w_onehot;
  assign w_chord       = (w_rise != '0) && !w_onehot;
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_counter == C_TO_LAST);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
      r_valid   <= 1'b0;
      r_color   <= COLOR_GREEN;
      r_led     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_counter <= w_counter_next;
      r_valid   <= w_valid_next;
      r_color   <= w_color_next;
      r_led     <= w_led_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_counter_next = r_counter;
    w_valid_next   = r_valid;
    w_color_next   = r_color;
    w_led_next     = r_led;
    w_timeout_next = 1'b0;

    if (r_valid && press.press_ready) w_valid_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_counter_next = '0;
        w_led_next     = '0;
        if (arm) w_state_next = ST_WAIT_PRESS;
      end

      ST_WAIT_PRESS: begin
        if (r_counter != C_CNT_MAX) w_counter_next = r_counter + CNT_W'(1);
        if (!arm) begin
          w_state_next   = ST_IDLE;
          w_counter_next = '0;
        end else if (w_accept) begin
          // Accepted press beats a coincident timeout.
          w_valid_next = 1'b1;
          w_color_next = encode_color(clean_btn);
          w_led_next   = clean_btn;
          w_state_next = ST_WAIT_RELEASE;
        end else if (w_timeout_hit) begin
          w_timeout_next = 1'b1;
          w_counter_next = '0;
          w_state_next   = ST_IDLE;
        end else if (w_chord) begin
          w_led_next   = '0;
          w_state_next = ST_WAIT_RELEASE;
        end
      end

      ST_WAIT_RELEASE: begin
        if ((clean_btn == '0) && !r_valid) begin
          w_led_next     = '0;
          w_counter_next = '0;
          w_state_next   = arm ? ST_WAIT_PRESS : ST_IDLE;
        end
      end

      default: begin
        w_state_next   = ST_IDLE;
        w_counter_next = '0;
        w_led_next     = '0;
      end
    endcase
  end

  assign press.press_valid = r_valid;
  assign press.press_color = r_color;
  assign timeout           = r_timeout;
  assign led_echo          = r_led;

endmodule

`default_nettype wire
